// File: rtl/sort_pkt_arbiter_if.sv
// sort_pkt_arbiter_if
// Bundles the requester-side Avalon-ST sinks (flattened NUM_SRC lanes) and
// the single Avalon-ST source that feeds the sorter, plus the error counter.
//   snk_*   : NUM_SRC requester lanes (data is NUM_SRC*DWIDTH, lane i at [i*DWIDTH +: DWIDTH])
//   src_*   : one packet stream toward the sorter, src_channel_o = granted lane
//   err_cnt_o : saturating protocol-error count
// Modports: master = environment (requesters + sorter), slave = the arbiter.
interface sort_pkt_arbiter_if #(
  parameter int DWIDTH  = 8,
  parameter int NUM_SRC = 4
);
  localparam int CH_W = $clog2(NUM_SRC);

  logic [NUM_SRC*DWIDTH-1:0] snk_data_i;
  logic [NUM_SRC-1:0]        snk_startofpacket_i;
  logic [NUM_SRC-1:0]        snk_endofpacket_i;
  logic [NUM_SRC-1:0]        snk_valid_i;
  logic [NUM_SRC-1:0]        snk_ready_o;
  logic [DWIDTH-1:0]         src_data_o;
  logic                      src_startofpacket_o;
  logic                      src_endofpacket_o;
  logic                      src_valid_o;
  logic [CH_W-1:0]           src_channel_o;
  logic                      src_ready_i;
  logic [15:0]               err_cnt_o;

  modport master (
    output snk_data_i, snk_startofpacket_i, snk_endofpacket_i, snk_valid_i,
    input  snk_ready_o,
    input  src_data_o, src_startofpacket_o, src_endofpacket_o, src_valid_o, src_channel_o,
    output src_ready_i,
    input  err_cnt_o
  );

  modport slave (
    input  snk_data_i, snk_startofpacket_i, snk_endofpacket_i, snk_valid_i,
    output snk_ready_o,
    output src_data_o, src_startofpacket_o, src_endofpacket_o, src_valid_o, src_channel_o,
    input  src_ready_i,
    output err_cnt_o
  );
endinterface

// File: rtl/sort_pkt_arbiter.sv
// sort_pkt_arbiter
// Packet-level round-robin arbiter sharing one sorter among NUM_SRC requesters.
// A whole packet is granted at once; beats go through a one-deep output
// register tagged with the granted lane on src_channel_o. Packets longer than
// MAX_PKT_LEN are cut (EOP forced on the last allowed beat) and the remainder
// is flushed. Orphan beats (valid without SOP from a non-granted lane) are
// accepted and dropped. Both cut packets and orphans bump err_cnt_o.
// Ports:
//   clk_i  : clock
//   srst_i : synchronous active-high reset
//   bus    : sort_pkt_arbiter_if.slave (requester sinks, sorter source, err_cnt_o)
module sort_pkt_arbiter #(
  parameter int DWIDTH      = 8,
  parameter int NUM_SRC     = 4,
  parameter int MAX_PKT_LEN = 256
) (
  input  logic              clk_i,
  input  logic              srst_i,
  sort_pkt_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_SRC);
  localparam int CW1  = CH_W + 1;
  localparam int BC_W = $clog2(MAX_PKT_LEN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CH_W-1:0]    grant_r;
  logic [CH_W-1:0]    last_grant_r;
  logic [CH_W-1:0]    pick_s;
  logic               pick_vld_s;
  logic [CW1-1:0]     cand_s;
  logic [BC_W-1:0]    beat_cnt_r;
  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] orphan_s;
  logic [NUM_SRC-1:0] gnt_oh_s;
  logic [NUM_SRC-1:0] ready_s;
  logic [DWIDTH-1:0]  sel_data_s;
  logic               sel_valid_s;
  logic               sel_sop_s;
  logic               sel_eop_s;
  logic               lane_rdy_s;
  logic               accept_s;
  logic               trunc_s;
  logic               grant_upd_s;
  logic [DWIDTH-1:0]  data_r;
  logic               sop_r;
  logic               eop_r;
  logic               valid_r;
  logic [CH_W-1:0]    channel_r;
  logic [15:0]        err_cnt_r;
  logic [16:0]        err_inc_s;
  logic [16:0]        err_sum_s;

  // Per-lane request, orphan and grant one-hot decode.
  // In IDLE no lane owns the bus, so any non-SOP beat is an orphan.
  always_comb begin
    req_s    = '0;
    orphan_s = '0;
    gnt_oh_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req_s[i]    = bus.snk_valid_i[i] & bus.snk_startofpacket_i[i];
      gnt_oh_s[i] = (grant_r == CH_W'(i));
      if ((state_r != ST_IDLE) && gnt_oh_s[i]) begin
        orphan_s[i] = 1'b0;
      end else begin
        orphan_s[i] = bus.snk_valid_i[i] & ~bus.snk_startofpacket_i[i];
      end
    end
  end

  // Mux the granted lane's beat (AND-OR select, grant is one-hot).
  always_comb begin
    sel_data_s  = '0;
    sel_valid_s = 1'b0;
    sel_sop_s   = 1'b0;
    sel_eop_s   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data_s  = sel_data_s | ({DWIDTH{gnt_oh_s[i]}} & bus.snk_data_i[i*DWIDTH +: DWIDTH]);
      sel_valid_s = sel_valid_s | (gnt_oh_s[i] & bus.snk_valid_i[i]);
      sel_sop_s   = sel_sop_s   | (gnt_oh_s[i] & bus.snk_startofpacket_i[i]);
      sel_eop_s   = sel_eop_s   | (gnt_oh_s[i] & bus.snk_endofpacket_i[i]);
    end
  end

  // Rotating priority search starting one past the last granted lane.
  always_comb begin
    pick_s     = '0;
    pick_vld_s = 1'b0;
    cand_s     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand_s = {1'b0, last_grant_r} + CW1'(k);
      if (cand_s >= CW1'(NUM_SRC)) begin
        cand_s = cand_s - CW1'(NUM_SRC);
      end else begin
        cand_s = cand_s;
      end
      if (!pick_vld_s && req_s[cand_s[CH_W-1:0]]) begin
        pick_vld_s = 1'b1;
        pick_s     = cand_s[CH_W-1:0];
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // FSM next state plus granted-lane handshake decisions.
  always_comb begin
    state_nxt_s = state_r;
    lane_rdy_s  = 1'b0;
    accept_s    = 1'b0;
    trunc_s     = 1'b0;
    grant_upd_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          grant_upd_s = 1'b1;
          state_nxt_s = ST_LOCKED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        // A sorter stall reaches the granted lane in the same cycle.
        lane_rdy_s = !valid_r || bus.src_ready_i;
        if (sel_valid_s && lane_rdy_s) begin
          accept_s = 1'b1;
          if (sel_eop_s) begin
            state_nxt_s = ST_IDLE;
          end else if (beat_cnt_r == BC_W'(MAX_PKT_LEN - 1)) begin
            trunc_s     = 1'b1;
            state_nxt_s = ST_FLUSH;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      ST_FLUSH: begin
        lane_rdy_s = 1'b1;
        if (sel_valid_s && sel_eop_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sink ready: orphans always drain, granted lane per FSM; nothing during reset.
  always_comb begin
    ready_s = '0;
    if (srst_i) begin
      ready_s = '0;
    end else begin
      ready_s = orphan_s | (gnt_oh_s & {NUM_SRC{lane_rdy_s}});
    end
  end

  // Error increment: one per dropped orphan beat plus one per truncation.
  always_comb begin
    err_inc_s = {16'd0, trunc_s};
    for (int i = 0; i < NUM_SRC; i++) begin
      err_inc_s = err_inc_s + {16'd0, orphan_s[i]};
    end
    err_sum_s = {1'b0, err_cnt_r} + err_inc_s;
  end

  // State, grant, last grant and beat counter registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= CH_W'(NUM_SRC - 1);
      beat_cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_upd_s) begin
        grant_r      <= pick_s;
        last_grant_r <= pick_s;
        beat_cnt_r   <= '0;
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + BC_W'(1);
      end
    end
  end

  // One-deep output register toward the sorter.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_r    <= '0;
      sop_r     <= 1'b0;
      eop_r     <= 1'b0;
      valid_r   <= 1'b0;
      channel_r <= '0;
    end else if (accept_s) begin
      data_r    <= sel_data_s;
      sop_r     <= sel_sop_s;
      eop_r     <= sel_eop_s | trunc_s;
      valid_r   <= 1'b1;
      channel_r <= grant_r;
    end else if (bus.src_ready_i) begin
      valid_r <= 1'b0;
    end
  end

  // Saturating error counter.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      err_cnt_r <= 16'd0;
    end else if (err_sum_s > 17'h0FFFF) begin
      err_cnt_r <= 16'hFFFF;
    end else begin
      err_cnt_r <= err_sum_s[15:0];
    end
  end

  assign bus.snk_ready_o         = ready_s;
  assign bus.src_data_o          = data_r;
  assign bus.src_startofpacket_o = sop_r;
  assign bus.src_endofpacket_o   = eop_r;
  assign bus.src_valid_o         = valid_r;
  assign bus.src_channel_o       = channel_r;
  assign bus.err_cnt_o           = err_cnt_r;
endmodule

// File: tb/tb_sort_pkt_arbiter.sv
// tb_sort_pkt_arbiter
// Drives per-requester packet queues into sort_pkt_arbiter and compares the
// beats delivered to the sorter against a packet-level round-robin model.
module tb_sort_pkt_arbiter;
  localparam int MAXL = 8;

  typedef struct packed {logic [7:0] d; logic sop; logic eop;} beat_t;
  typedef struct packed {logic [7:0] d; logic sop; logic eop; logic [1:0] ch;} obs_t;

  logic clk;
  logic srst;
  int   checks = 0;
  int   errors = 0;

  beat_t src_q[4][$];
  obs_t  obs_q[$];
  obs_t  exp_q[$];
  int    exp_err;

  sort_pkt_arbiter_if #(.DWIDTH(8), .NUM_SRC(4)) bus ();

  sort_pkt_arbiter #(.DWIDTH(8), .NUM_SRC(4), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.snk_data_i          = '0;
    bus.snk_startofpacket_i = '0;
    bus.snk_endofpacket_i   = '0;
    bus.snk_valid_i         = '0;
    bus.src_ready_i         = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    srst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    for (int s = 0; s < 4; s++) src_q[s].delete();
    obs_q.delete();
  endtask

  task automatic add_pkt(input int s, input int len, input logic [7:0] base, input bit rnd);
    beat_t b;
    for (int n = 1; n <= len; n++) begin
      b.d   = rnd ? 8'($urandom_range(0, 255)) : 8'(base + 8'(n - 1));
      b.sop = (n == 1);
      b.eop = (n == len);
      src_q[s].push_back(b);
    end
  endtask

  // Reference: whole packets served round-robin from last lane 3, each cut to
  // MAXL beats with EOP forced on beat MAXL and one error per cut packet.
  function automatic void build_model();
    beat_t q[4][$];
    beat_t b;
    obs_t  o;
    int    last, s, n;
    bit    found;
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < 4; i++) q[i] = src_q[i];
    last = 3;
    while (1) begin
      found = 0;
      s = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && q[(last + k) % 4].size() > 0) begin
          s = (last + k) % 4;
          found = 1;
        end
      end
      if (!found) break;
      last = s;
      n = 0;
      while (q[s].size() > 0) begin
        b = q[s].pop_front();
        n++;
        if (n <= MAXL) begin
          o.d = b.d; o.sop = b.sop; o.eop = b.eop || (n == MAXL); o.ch = 2'(s);
          exp_q.push_back(o);
        end
        if (n == MAXL && !b.eop) exp_err++;
        if (b.eop) break;
      end
    end
  endfunction

  // Per-cycle driver/monitor. rdy_mode 0: always ready, 1: random, 2: 1,0,0 repeating.
  task automatic run_stream(input int max_cyc, input int rdy_mode, input int orphan_at,
                            output logic orphan_rdy, output logic done);
    logic [3:0] acc;
    bit         empty;
    int         cyc;
    cyc = 0;
    done = 1'b0;
    orphan_rdy = 1'b0;
    while (cyc < max_cyc && !done) begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus.src_ready_i = 1'b1;
        1:       bus.src_ready_i = ($urandom_range(0, 3) != 0);
        default: bus.src_ready_i = (cyc % 3 == 0);
      endcase
      empty = 1;
      for (int s = 0; s < 4; s++) begin
        if (src_q[s].size() > 0) begin
          empty = 0;
          bus.snk_valid_i[s]         = 1'b1;
          bus.snk_data_i[s*8 +: 8]   = src_q[s][0].d;
          bus.snk_startofpacket_i[s] = src_q[s][0].sop;
          bus.snk_endofpacket_i[s]   = src_q[s][0].eop;
        end else begin
          bus.snk_valid_i[s]         = 1'b0;
          bus.snk_data_i[s*8 +: 8]   = 8'h00;
          bus.snk_startofpacket_i[s] = 1'b0;
          bus.snk_endofpacket_i[s]   = 1'b0;
        end
      end
      if (cyc == orphan_at && src_q[3].size() == 0) begin
        bus.snk_valid_i[3]         = 1'b1;
        bus.snk_startofpacket_i[3] = 1'b0;
        bus.snk_data_i[31:24]      = 8'hEE;
      end
      #1;
      if (cyc == orphan_at) orphan_rdy = bus.snk_ready_o[3];
      acc = bus.snk_valid_i & bus.snk_ready_o;
      if (bus.src_valid_o && bus.src_ready_i)
        obs_q.push_back({bus.src_data_o, bus.src_startofpacket_o, bus.src_endofpacket_o, bus.src_channel_o});
      if (empty && !bus.src_valid_o && cyc != orphan_at) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        for (int s = 0; s < 4; s++)
          if (acc[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
        cyc++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    srst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    checks++; if (bus.src_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.src_valid_o); end
    checks++; if (bus.src_startofpacket_o !== 1'b0 || bus.src_endofpacket_o !== 1'b0) begin errors++; $display("FAIL reset_sop_eop: got %b%b expected 00", bus.src_startofpacket_o, bus.src_endofpacket_o); end
    checks++; if (bus.src_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.src_data_o); end
    checks++; if (bus.src_channel_o !== 2'd0) begin errors++; $display("FAIL reset_channel: got %0d expected 0", bus.src_channel_o); end
    checks++; if (bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", bus.err_cnt_o); end
    checks++; if (bus.snk_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.snk_ready_o); end
    @(negedge clk);
    srst = 1'b0;
  endtask

  // Compares observed against expected stream, error count and completion.
  task automatic test_stream(input string name, input int max_cyc, input int rdy_mode);
    logic orp, done;
    build_model();
    run_stream(max_cyc, rdy_mode, -1, orp, done);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1 within %0d cycles", name, done, max_cyc); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count: got %0d beats expected %0d", name, obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_beat%0d: got d=%h sop=%b eop=%b ch=%0d expected d=%h sop=%b eop=%b ch=%0d", name, i, obs_q[i].d, obs_q[i].sop, obs_q[i].eop, obs_q[i].ch, exp_q[i].d, exp_q[i].sop, exp_q[i].eop, exp_q[i].ch); end
    end
    checks++; if (bus.err_cnt_o !== 16'(exp_err)) begin errors++; $display("FAIL %s_err: got %0d expected %0d", name, bus.err_cnt_o, exp_err); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 4; s++) add_pkt(s, 3, 8'(8'h10 * s + 8'h40 * p), 0);
    test_stream("rr", 200, 0);
  endtask

  task automatic test_backpressure();
    apply_reset();
    add_pkt(1, 5, 8'h11, 0);
    test_stream("bp", 200, 2);
  endtask

  task automatic test_oversize();
    apply_reset();
    add_pkt(2, 12, 8'h20, 0);
    add_pkt(3, 2, 8'h30, 0);
    test_stream("oversize", 200, 0);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    add_pkt(0, 1, 8'hA0, 0);
    add_pkt(2, 1, 8'hA2, 0);
    test_stream("single", 100, 0);
  endtask

  task automatic test_orphan();
    logic orp, done;
    apply_reset();
    add_pkt(0, 4, 8'hB1, 0);
    build_model();
    run_stream(100, 0, 3, orp, done);
    checks++; if (orp !== 1'b1) begin errors++; $display("FAIL orphan_ready: got %b expected 1", orp); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL orphan_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL orphan_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (bus.err_cnt_o !== 16'(exp_err + 1)) begin errors++; $display("FAIL orphan_err: got %0d expected %0d", bus.err_cnt_o, exp_err + 1); end
  endtask

  task automatic test_reset_mid();
    logic orp, done;
    apply_reset();
    add_pkt(0, 4, 8'hC1, 0);
    run_stream(3, 0, -1, orp, done);
    checks++; if (bus.src_valid_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", bus.src_valid_o); end
    @(negedge clk);
    srst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    checks++; if ({bus.src_valid_o, bus.src_startofpacket_o, bus.src_endofpacket_o} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %b expected 000", {bus.src_valid_o, bus.src_startofpacket_o, bus.src_endofpacket_o}); end
    checks++; if ({bus.src_data_o, bus.src_channel_o} !== 10'd0) begin errors++; $display("FAIL midrst_data_ch: got %h/%0d expected 00/0", bus.src_data_o, bus.src_channel_o); end
    checks++; if (bus.snk_ready_o !== 4'b0000 || bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL midrst_ready_err: got %b/%0d expected 0000/0", bus.snk_ready_o, bus.err_cnt_o); end
    @(negedge clk);
    srst = 1'b0;
    for (int s = 0; s < 4; s++) src_q[s].delete();
    obs_q.delete();
    add_pkt(1, 3, 8'hD1, 0);
    test_stream("midrst_after", 100, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      for (int s = 0; s < 4; s++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, 12), 8'h00, 1);
      end
      test_stream("random", 3000, 1);
    end
  endtask

  initial begin
    srst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_oversize();
    test_orphan();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
